// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN feature-map datapath.
// Layer output dimensions and the capture/replay state encoding.
package cnn_pkg;

  localparam int DWIDTH_DEF  = 32;

  localparam int CONV1_OUT_W = 28;
  localparam int CONV1_OUT_H = 28;
  localparam int CONV2_OUT_W = 10;
  localparam int CONV2_OUT_H = 10;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } sink_state_e;

endpackage

// File: rtl/fm_buffer_ram.sv
// Simple dual-port frame buffer: one write port, one synchronous read port.
// The array has no reset; read data holds while i_rd_en is low.
module fm_buffer_ram
  import cnn_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = CONV1_OUT_W * CONV1_OUT_H,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [AWIDTH-1:0] i_wr_addr,
  input  logic [DWIDTH-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [AWIDTH-1:0] i_rd_addr,
  output logic [DWIDTH-1:0] o_rd_data
);

  logic [DWIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/fm_stream_sink.sv
// Captures one OUT_W x OUT_H feature map from a valid-only stream and
// replays it over a valid/ready stream with end-of-frame marking.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FILL  | accepting input words into the buffer at wr_ptr
// ST_DRAIN | buffer full, replaying words 0..DEPTH-1 to the downstream
module fm_stream_sink
  import cnn_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int OUT_W  = CONV1_OUT_W,
  parameter int OUT_H  = CONV1_OUT_H
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              data_valid,
  input  logic              flush,
  input  logic              clear_err,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              frame_done,
  output logic              busy,
  output logic              overflow
);

  localparam int DEPTH  = OUT_W * OUT_H;
  localparam int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  sink_state_e       r_state, w_state_nxt;
  logic [AWIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic              r_rd_done;
  logic              r_q_vld, r_q_last;
  logic [DWIDTH-1:0] r_m_data, w_rd_data;
  logic              r_m_valid, r_m_last;
  logic              r_frame_done, r_ovf;
  logic              w_wr_en, w_last_wr, w_rd_en, w_out_load, w_last_xfer, w_ovf_set;

  assign w_wr_en     = data_valid & (r_state == ST_FILL) & ~flush;
  assign w_last_wr   = w_wr_en & (r_wr_ptr == LAST_ADDR);
  assign w_out_load  = ~r_m_valid | m_ready;
  assign w_last_xfer = r_m_valid & m_ready & r_m_last;
  assign w_ovf_set   = data_valid & (r_state == ST_DRAIN) & ~flush;

  // Word 0 is prefetched during the final write so m_valid trails frame_done by one cycle.
  assign w_rd_en = ~flush & (w_last_wr |
                   ((r_state == ST_DRAIN) & ~r_rd_done & (~r_q_vld | w_out_load)));

  fm_buffer_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .i_clk     (clock),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_in),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL:  if (w_last_wr)   w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_last_xfer) w_state_nxt = ST_FILL;
        default:                   w_state_nxt = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_done <= 1'b0;
      r_q_vld   <= 1'b0;
      r_q_last  <= 1'b0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_done <= 1'b0;
      r_q_vld   <= 1'b0;
      r_q_last  <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd_en) begin
        r_rd_ptr  <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
        r_rd_done <= (r_rd_ptr == LAST_ADDR);
        r_q_last  <= (r_rd_ptr == LAST_ADDR);
      end else if (w_last_xfer) begin
        r_rd_done <= 1'b0;
      end
      // RAM output acts as a second pipeline slot behind the output register.
      r_q_vld <= w_rd_en | (r_q_vld & ~w_out_load);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (w_out_load) begin
      r_m_valid <= r_q_vld;
      r_m_last  <= r_q_vld & r_q_last;
      if (r_q_vld) r_m_data <= w_rd_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_frame_done <= w_last_wr;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (clear_err) r_ovf <= 1'b0;
    end
  end

  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;
  assign frame_done = r_frame_done;
  assign busy       = (r_state == ST_DRAIN);
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_fm_stream_sink.sv
// Scoreboard bench for fm_stream_sink: a 28x28 instance and a 10x10 instance,
// random data and ready patterns checked against a frame-level reference model.
module tb_fm_stream_sink;
  import cnn_pkg::*;

  localparam int DW      = DWIDTH_DEF;
  localparam int DEPTH_A = CONV1_OUT_W * CONV1_OUT_H;
  localparam int DEPTH_B = CONV2_OUT_W * CONV2_OUT_H;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic [DW-1:0] a_din, a_m_data, b_din, b_m_data;
  logic a_dv, a_flush, a_clr, a_m_valid, a_m_ready, a_m_last, a_fd, a_busy, a_ovf;
  logic b_dv, b_flush, b_clr, b_m_valid, b_m_ready, b_m_last, b_fd, b_busy, b_ovf;

  fm_stream_sink #(.DWIDTH(DW), .OUT_W(CONV1_OUT_W), .OUT_H(CONV1_OUT_H)) dut_a (
    .clock(clock), .reset(reset), .data_in(a_din), .data_valid(a_dv), .flush(a_flush),
    .clear_err(a_clr), .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
    .m_last(a_m_last), .frame_done(a_fd), .busy(a_busy), .overflow(a_ovf));

  fm_stream_sink #(.DWIDTH(DW), .OUT_W(CONV2_OUT_W), .OUT_H(CONV2_OUT_H)) dut_b (
    .clock(clock), .reset(reset), .data_in(b_din), .data_valid(b_dv), .flush(b_flush),
    .clear_err(b_clr), .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_last(b_m_last), .frame_done(b_fd), .busy(b_busy), .overflow(b_ovf));

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  exp_t          qa[$], qb[$];
  logic [DW-1:0] fa[$], fb[$];
  int n_pass = 0, n_total = 0;
  int a_fd_cnt = 0, a_fd_exp = 0, b_fd_cnt = 0, b_fd_exp = 0;
  int a_xfer = 0, b_xfer = 0;
  bit a_rmode = 0, b_rmode = 0;

  task automatic check_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic check_b(input string name, input logic act, input logic req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %b required %b", name, act, req);
  endtask

  task automatic sync();
    @(posedge clock); #1;
  endtask

  // Reference model: a frame becomes expected output once DEPTH words are captured.
  task automatic model_word(input bit sel, input logic [DW-1:0] d, output bit done);
    done = 1'b0;
    if (!sel) begin
      fa.push_back(d);
      if (fa.size() == DEPTH_A) begin
        for (int k = 0; k < DEPTH_A; k++) qa.push_back('{fa[k], k == DEPTH_A - 1});
        fa.delete(); a_fd_exp++; done = 1'b1;
      end
    end else begin
      fb.push_back(d);
      if (fb.size() == DEPTH_B) begin
        for (int k = 0; k < DEPTH_B; k++) qb.push_back('{fb[k], k == DEPTH_B - 1});
        fb.delete(); b_fd_exp++; done = 1'b1;
      end
    end
  endtask

  // Starts and (without timing check) ends at posedge+1; with timing check ends one
  // negedge after m_valid is required to have risen.
  task automatic send_frame(input bit sel, input int n, input int gap,
                            input bit idx_data, input bit chk_timing);
    logic [DW-1:0] d;
    bit done;
    done = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) sync();
      d = idx_data ? DW'(i) : DW'($urandom());
      if (sel) begin b_dv = 1'b1; b_din = d; end
      else     begin a_dv = 1'b1; a_din = d; end
      model_word(sel, d, done);
      sync();
      a_dv = 1'b0; b_dv = 1'b0;
    end
    if (chk_timing && done) begin
      @(negedge clock);
      check_b("frame_done_pulse", sel ? b_fd : a_fd, 1'b1);
      check_b("valid_after_last_write", sel ? b_m_valid : a_m_valid, 1'b0);
      check_b("busy_in_prefetch", sel ? b_busy : a_busy, 1'b1);
      @(negedge clock);
      check_b("frame_done_single", sel ? b_fd : a_fd, 1'b0);
      check_b("first_valid", sel ? b_m_valid : a_m_valid, 1'b1);
    end
  endtask

  task automatic wait_idle(input bit sel);
    int cyc;
    cyc = 0;
    @(negedge clock);
    while (((sel ? b_busy : a_busy) || (sel ? qb.size() : qa.size()) != 0) && cyc < 20000) begin
      @(negedge clock); cyc++;
    end
    if (cyc >= 20000) begin
      n_total++;
      $display("FAIL drain_timeout: actual busy after %0d cycles required idle", cyc);
    end
    check_b("idle_busy", sel ? b_busy : a_busy, 1'b0);
    check_b("idle_valid", sel ? b_m_valid : a_m_valid, 1'b0);
    sync();
  endtask

  initial begin
    a_m_ready = 1'b1; b_m_ready = 1'b1;
    forever begin
      sync();
      a_m_ready = a_rmode ? 1'($urandom_range(0, 1)) : 1'b1;
      b_m_ready = b_rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic [DW-1:0] a_prev_d, b_prev_d;
  logic a_prev_l, b_prev_l, a_stall = 0, b_stall = 0;
  exp_t ea, eb;

  initial forever begin
    @(negedge clock);
    if (a_stall) begin
      check_b("a_hold_valid", a_m_valid, 1'b1);
      check_w("a_hold_data", a_m_data, a_prev_d);
      check_b("a_hold_last", a_m_last, a_prev_l);
    end
    if (a_m_valid && a_m_ready) begin
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL a_unexpected_word: actual %0h required no word", a_m_data);
      end else begin
        ea = qa.pop_front();
        check_w("a_data", a_m_data, ea.d);
        check_b("a_last", a_m_last, ea.last);
      end
      a_xfer++;
    end
    a_stall = a_m_valid && !a_m_ready;
    a_prev_d = a_m_data; a_prev_l = a_m_last;
    if (a_fd) a_fd_cnt++;
  end

  initial forever begin
    @(negedge clock);
    if (b_stall) begin
      check_b("b_hold_valid", b_m_valid, 1'b1);
      check_w("b_hold_data", b_m_data, b_prev_d);
      check_b("b_hold_last", b_m_last, b_prev_l);
    end
    if (b_m_valid && b_m_ready) begin
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL b_unexpected_word: actual %0h required no word", b_m_data);
      end else begin
        eb = qb.pop_front();
        check_w("b_data", b_m_data, eb.d);
        check_b("b_last", b_m_last, eb.last);
      end
      b_xfer++;
    end
    b_stall = b_m_valid && !b_m_ready;
    b_prev_d = b_m_data; b_prev_l = b_m_last;
    if (b_fd) b_fd_cnt++;
  end

  initial begin
    int cyc, x0;
    reset = 1'b0;
    a_din = '0; a_dv = 0; a_flush = 0; a_clr = 0;
    b_din = '0; b_dv = 0; b_flush = 0; b_clr = 0;
    #2;
    check_b("rst_valid", a_m_valid, 1'b0);
    check_b("rst_last", a_m_last, 1'b0);
    check_w("rst_data", a_m_data, '0);
    check_b("rst_fd", a_fd, 1'b0);
    check_b("rst_busy", a_busy, 1'b0);
    check_b("rst_ovf", a_ovf, 1'b0);
    check_b("rst_b_busy", b_busy, 1'b0);
    @(posedge clock); #3; reset = 1'b1;
    sync();

    // 1: index data, ready held high, contiguous replay
    send_frame(0, DEPTH_A, 0, 1, 1);
    cyc = 0;
    while (a_busy && cyc < 5000) begin @(negedge clock); cyc++; end
    check_w("drain_cycles", DW'(cyc), DW'(DEPTH_A));
    check_w("drain_queue_empty", DW'(qa.size()), '0);
    sync();
    wait_idle(0);

    // 2: gapped input, random ready
    a_rmode = 1;
    send_frame(0, DEPTH_A, 2, 0, 1);
    wait_idle(0);

    // 3: overflow set / hold / set-beats-clear / clear
    send_frame(0, DEPTH_A, 0, 0, 1);
    repeat (3) sync();
    a_dv = 1'b1; a_din = DW'($urandom());
    sync(); a_dv = 1'b0;
    @(negedge clock);
    check_b("ovf_set", a_ovf, 1'b1);
    check_b("ovf_busy", a_busy, 1'b1);
    repeat (4) sync();
    @(negedge clock);
    check_b("ovf_hold", a_ovf, 1'b1);
    sync();
    a_dv = 1'b1; a_clr = 1'b1; a_din = DW'($urandom());
    sync(); a_dv = 1'b0; a_clr = 1'b0;
    @(negedge clock);
    check_b("ovf_set_wins", a_ovf, 1'b1);
    sync();
    a_clr = 1'b1;
    sync(); a_clr = 1'b0;
    @(negedge clock);
    check_b("ovf_cleared", a_ovf, 1'b0);
    wait_idle(0);

    // 4: flush after a partial frame, data_valid with flush dropped
    send_frame(0, 400, 1, 0, 0);
    a_flush = 1'b1; a_dv = 1'b1; a_din = DW'($urandom());
    fa.delete();
    sync(); a_flush = 1'b0; a_dv = 1'b0;
    @(negedge clock);
    check_b("flush_busy", a_busy, 1'b0);
    check_b("flush_valid", a_m_valid, 1'b0);
    check_b("flush_no_ovf", a_ovf, 1'b0);
    check_b("flush_no_fd", a_fd, 1'b0);
    sync();
    send_frame(0, DEPTH_A, 0, 0, 1);
    wait_idle(0);

    // 5: async reset mid-drain at word 300
    a_rmode = 0;
    x0 = a_xfer;
    send_frame(0, DEPTH_A, 0, 0, 1);
    cyc = 0;
    while (a_xfer < x0 + 300 && cyc < 5000) begin @(negedge clock); cyc++; end
    check_w("reached_word_300", DW'(a_xfer - x0), DW'(300));
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check_b("areset_valid", a_m_valid, 1'b0);
    check_b("areset_busy", a_busy, 1'b0);
    check_b("areset_last", a_m_last, 1'b0);
    qa.delete(); fa.delete(); qb.delete(); fb.delete();
    @(posedge clock); #3;
    reset = 1'b1;
    sync();
    a_rmode = 1;
    send_frame(0, DEPTH_A, 0, 0, 1);
    wait_idle(0);

    // 6: 10x10 instance, non-power-of-two depth, two frames for pointer wrap
    send_frame(1, DEPTH_B, 0, 1, 1);
    wait_idle(1);
    b_rmode = 1;
    send_frame(1, DEPTH_B, 2, 0, 1);
    wait_idle(1);

    check_w("a_fd_count", DW'(a_fd_cnt), DW'(a_fd_exp));
    check_w("b_fd_count", DW'(b_fd_cnt), DW'(b_fd_exp));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fm_stream_sink.md
Name: fm_stream_sink

Overview:
- Receiving end of the conv-layer output stream (data_out / data_valid_out of a feature-map convolution unit).
- Captures one complete OUT_W x OUT_H feature map into an internal buffer, arriving as valid-only, no-backpressure raster order.
- Replays the map to the next layer (pooling / next conv) over a valid/ready stream with end-of-frame marking.
- Detects and flags input arriving while the buffer is unavailable.

Parameters:
DWIDTH, 32, word width (IEEE-754 single, matching the conv weight/data format)
OUT_W, 28, feature-map width in words
OUT_H, 28, feature-map height in words
DEPTH, OUT_W*OUT_H, buffer depth (derived, not to be overridden)
AWIDTH, $clog2(DEPTH), buffer address width (derived)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
data_in  in  DWIDTH  conv output word
data_valid  in  1  data_in valid this cycle; no backpressure possible
flush  in  1  synchronous abort: discard buffer, re-arm for a new frame
clear_err  in  1  synchronous clear of overflow
m_data  out  DWIDTH  replayed word
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts m_data when m_valid & m_ready
m_last  out  1  high with the final word (index DEPTH-1) of the frame
frame_done  out  1  one-cycle pulse when the final input word is written
busy  out  1  high in DRAIN
overflow  out  1  sticky: data_valid seen while not in FILL

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to FILL; wr_ptr=0, rd_ptr=0.
  - m_valid=0, m_last=0, m_data=0, frame_done=0, busy=0, overflow=0.
  - Buffer contents are undefined.
- States: FILL, DRAIN.
- FILL:
  - Each cycle with data_valid=1: write data_in at wr_ptr, then wr_ptr++.
  - When a write occurs at wr_ptr==DEPTH-1:
    - Next state is DRAIN; wr_ptr wraps to 0.
    - frame_done=1 in the following cycle only.
- DRAIN:
  - Buffer is read through a 1-cycle synchronous RAM plus a one-entry output register.
  - First m_valid=1 exactly 2 cycles after the clock edge that wrote the last input word (frame_done and m_valid are not simultaneous; m_valid follows frame_done by 1 cycle).
  - While m_ready=1, one word is transferred per cycle with no bubbles.
  - While m_valid=1 and m_ready=0: m_data, m_last and m_valid hold stable. No word is skipped or duplicated.
  - Words leave in write order, indices 0..DEPTH-1. m_last=1 only with index DEPTH-1.
  - On the transfer of the last word (m_valid & m_ready & m_last):
    - Next state is FILL; rd_ptr=0.
    - m_valid=0 the next cycle unless a new frame is ready (it cannot be, by construction).
- busy=1 exactly while in DRAIN, including the prefetch cycle.
- data_valid outside FILL:
  - The word is dropped and no pointer changes.
  - overflow is set the next cycle and stays set until clear_err or reset.
  - If clear_err and a new overflow event occur in the same cycle, set wins.
- Back-to-back frames: a data_valid in the same cycle as the final m_last handshake is counted as overflow. The block re-arms only from the next cycle.
- flush=1 (any state):
  - Next cycle: state FILL, pointers 0, m_valid=0, m_last=0, busy=0.
  - frame_done is suppressed.
  - overflow is unaffected.
  - A data_valid coinciding with flush is dropped and does not set overflow.
- Reset mid-operation: the partial frame is lost and the block restarts in FILL as above.
- No arithmetic on data; words are stored bit-exact.
- Pointers count 0..DEPTH-1 and never exceed DEPTH-1, for any DEPTH, including non-power-of-two.

Decomposition:
- Shared package (cnn_pkg): DWIDTH default, feature-map dimension constants per layer (28x28 conv1, 10x10 conv2), and the FILL/DRAIN state enum.
- One sub-module: fm_buffer_ram.
  - Simple dual-port RAM: one write port, one read port, synchronous read, DEPTH x DWIDTH, no reset on the array.
- The FSM, pointers and output register stay in fm_stream_sink.

Test Plan:
1. Reset, then 784 consecutive data_valid with data_in=index -> frame_done pulse 1 cycle after word 783. With m_ready=1: m_valid rises the next cycle, 784 words 0..783 on consecutive cycles, m_last only on 783, then busy=0.
2. Gapped input (data_valid every 3rd cycle), m_ready toggling 1/0 pseudo-randomly -> exactly 784 transfers, values in order, m_data stable during every stall, no duplicates.
3. data_valid pulses during DRAIN -> words dropped, overflow=1 next cycle and held. clear_err in the same cycle as a new overflow pulse -> overflow stays 1. clear_err alone -> overflow=0.
4. flush after 400 input words -> next cycle in FILL. A following full 784-word frame replays correctly with no stale data and no early frame_done.
5. Asynchronous reset asserted mid-DRAIN (word 300 of 784, between clock edges) -> m_valid, busy, m_last go 0 immediately. A new frame is then captured and replayed correctly.
6. Parameters OUT_W=10, OUT_H=10 -> frame_done after 100 words, m_last on word 99, pointer wrap correct (non-power-of-two depth).
